scale_param_gen_multi: RTL and testbench

Parametrised per-scale parameter generator for the detection window pipeline. On `start` it walks a sequence of image scales, geometric or linear, up to `MAX_SCALES` entries. For each scale it computes the inverse scale, the scaled image dimensions and the scaled window size. Each scale's parameters are emitted as one record over a valid/ready handshake to the downstream scaler/classifier scheduler. It replaces the fixed single-mode scale parameter FSM. It adds configurable fixed-point widths, a linear stepping mode, a scale-count limit, overflow termination and output back-pressure.

---
 rtl/scale_param_gen_multi.sv | 213 +++++++++++++++++++++
 tb/tb_scale_param_gen_multi.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/scale_param_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scale_param_gen_multi: per-scale inverse/size/window record generator     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module scale_param_gen_multi #(
  parameter int  DIM_W      = 10,
  parameter int  FRAC       = 8,
  parameter int  INT_W      = 4,
  parameter int  MAX_SCALES = 16,
  localparam int SW         = INT_W + FRAC,
  localparam int IDX_W      = (MAX_SCALES > 1) ? $clog2(MAX_SCALES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [DIM_W-1:0]  base_win,
  input  logic [SW-1:0]     step,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [SW-1:0]     out_scale,
  output logic [FRAC:0]     out_inv,
  output logic [DIM_W-1:0]  out_w,
  output logic [DIM_W-1:0]  out_h,
  output logic [DIM_W-1:0]  out_win,
  output logic              done
);

  localparam int CNT_W    = $clog2(2 * FRAC + 1);
  localparam int DIV_LAST = 2 * FRAC;
  localparam int MW       = DIM_W + SW;
  localparam int NW       = 2 * SW;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_EMIT = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [DIM_W-1:0] img_w_q, img_w_d, img_h_q, img_h_d, base_win_q, base_win_d;
  logic [SW-1:0]    step_q, step_d, s_q, s_d, rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FRAC:0]    quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, out_valid_q, out_valid_d, done_q, done_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [SW-1:0]    out_scale_q, out_scale_d;
  logic [FRAC:0]    out_inv_q, out_inv_d;
  logic [DIM_W-1:0] out_w_q, out_w_d, out_h_q, out_h_d, out_win_q, out_win_d;

  logic [SW:0]      rem_sh;
  logic             rem_ge;
  logic [MW-1:0]    w_full, h_full, win_full;
  logic [NW-1:0]    s_next;
  logic             stop;

  always_comb begin
    // The dividend 2^(2*FRAC) contributes a single 1 bit on the first iteration.
    rem_sh   = {rem_q, (cnt_q == '0)};
    rem_ge   = (rem_sh >= {1'b0, s_q});
    w_full   = (MW'(img_w_q) * MW'(quo_q)) >> FRAC;
    h_full   = (MW'(img_h_q) * MW'(quo_q)) >> FRAC;
    win_full = (MW'(base_win_q) * MW'(s_q)) >> FRAC;
    s_next   = mode_q ? (NW'(s_q) + NW'(step_q))
                      : ((NW'(s_q) * NW'(step_q)) >> FRAC);
    stop     = (int'(idx_q) + 1 == MAX_SCALES) ||
               (s_next >= (NW'(1) << SW)) ||
               (s_next <= NW'(s_q));
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    img_w_d     = img_w_q;
    img_h_d     = img_h_q;
    base_win_d  = base_win_q;
    step_d      = step_q;
    s_d         = s_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    out_idx_d   = out_idx_q;
    out_scale_d = out_scale_q;
    out_inv_d   = out_inv_q;
    out_w_d     = out_w_q;
    out_h_d     = out_h_q;
    out_win_d   = out_win_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          img_w_d    = img_w;
          img_h_d    = img_h;
          base_win_d = base_win;
          step_d     = step;
          s_d        = SW'(1) << FRAC;
          idx_d      = '0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        rem_d = rem_ge ? SW'(rem_sh - {1'b0, s_q}) : SW'(rem_sh);
        quo_d = {quo_q[FRAC-1:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_LAST)) state_d = S_CALC;
      end
      S_CALC: begin
        if ((win_full > w_full) || (win_full > h_full)) begin
          state_d = S_DONE;
        end else begin
          out_idx_d   = idx_q;
          out_scale_d = s_q;
          out_inv_d   = quo_q;
          out_w_d     = DIM_W'(w_full);
          out_h_d     = DIM_W'(h_full);
          out_win_d   = DIM_W'(win_full);
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          s_d     = SW'(s_next);
          idx_d   = idx_q + 1'b1;
          state_d = S_INIT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    out_valid_d = (state_d == S_EMIT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      img_w_q     <= '0;
      img_h_q     <= '0;
      base_win_q  <= '0;
      step_q      <= '0;
      s_q         <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_idx_q   <= '0;
      out_scale_q <= '0;
      out_inv_q   <= '0;
      out_w_q     <= '0;
      out_h_q     <= '0;
      out_win_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      img_w_q     <= img_w_d;
      img_h_q     <= img_h_d;
      base_win_q  <= base_win_d;
      step_q      <= step_d;
      s_q         <= s_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_idx_q   <= out_idx_d;
      out_scale_q <= out_scale_d;
      out_inv_q   <= out_inv_d;
      out_w_q     <= out_w_d;
      out_h_q     <= out_h_d;
      out_win_q   <= out_win_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_idx   = out_idx_q;
  assign out_scale = out_scale_q;
  assign out_inv   = out_inv_q;
  assign out_w     = out_w_q;
  assign out_h     = out_h_q;
  assign out_win   = out_win_q;

endmodule
`default_nettype wire

// File: tb/tb_scale_param_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scale_param_gen_multi: directed run table for scale_param_gen_multi    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_scale_param_gen_multi;

  logic        clk = 1'b0;
  logic        reset, start, mode, out_ready;
  logic [9:0]  img_w, img_h, base_win;
  logic [11:0] step;
  logic        busy, out_valid, done;
  logic [3:0]  out_idx;
  logic [11:0] out_scale;
  logic [8:0]  out_inv;
  logic [9:0]  out_w, out_h, out_win;

  int n_vec  = 0;
  int n_fail = 0;

  scale_param_gen_multi #(
    .DIM_W(10), .FRAC(8), .INT_W(4), .MAX_SCALES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .img_w(img_w), .img_h(img_h), .base_win(base_win), .step(step),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_scale(out_scale), .out_inv(out_inv),
    .out_w(out_w), .out_h(out_h), .out_win(out_win), .done(done)
  );

  always #5 clk = ~clk;

  // s_kind: 0 = record table, 1 = 256 + step*idx, 2 = 256 << idx.
  // done_gap: cycles from the last handshake (or start presentation) to done.
  typedef struct {
    logic        mode;
    logic [9:0]  iw, ih, bw;
    logic [11:0] step;
    int          bp_rec;
    int          n_rec;
    int          s_kind;
    int          done_gap;
  } run_t;

  typedef struct {
    logic [11:0] s;
    logic [8:0]  inv;
    logic [9:0]  w, h, win;
  } rec_t;

  run_t runs[6];
  rec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_run(input run_t r);
    int          cyc, nrec, last_hs, stall;
    bit          seen, got_done;
    logic [54:0] cap;
    longint      exp_s;
    @(negedge clk);
    mode = r.mode; img_w = r.iw; img_h = r.ih; base_win = r.bw; step = r.step;
    start = 1'b1; out_ready = 1'b1;
    cyc = 0; nrec = 0; last_hs = 0; stall = 0; seen = 0; got_done = 0; cap = '0;
    while (!got_done && cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) chk("busy_rise", busy, 1);
      if (done) begin
        got_done = 1;
        chk("done_time", cyc, last_hs + r.done_gap);
        chk("done_vs_valid", out_valid, 0);
        chk("busy_at_done", busy, 0);
        chk("record_count", nrec, r.n_rec);
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1;
          chk("valid_time", cyc, last_hs + 20);
          chk("out_idx", out_idx, nrec);
          case (r.s_kind)
            1:       exp_s = 256 + longint'(r.step) * nrec;
            2:       exp_s = 256 << nrec;
            default: exp_s = (nrec < 6) ? longint'(tbl[nrec].s) : -1;
          endcase
          chk("out_scale", out_scale, exp_s);
          if (r.s_kind == 0 && nrec < 6) begin
            chk("out_inv", out_inv, tbl[nrec].inv);
            chk("out_w",   out_w,   tbl[nrec].w);
            chk("out_h",   out_h,   tbl[nrec].h);
            chk("out_win", out_win, tbl[nrec].win);
          end
          cap = {out_idx, out_scale, out_inv, out_w, out_h, out_win};
        end else begin
          chk("hold_stable", {out_idx, out_scale, out_inv, out_w, out_h, out_win}, cap);
        end
        if (nrec == r.bp_rec && stall < 7) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
          last_hs = cyc + 1;
          nrec++;
          seen = 0;
        end
      end
    end
    if (!got_done) chk("done_timeout", 0, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int hs, cyc, done_seen;
    tbl[0] = '{12'd256, 9'd256, 10'd320, 10'd240, 10'd24};
    tbl[1] = '{12'd320, 9'd204, 10'd255, 10'd191, 10'd30};
    tbl[2] = '{12'd400, 9'd163, 10'd203, 10'd152, 10'd37};
    tbl[3] = '{12'd500, 9'd131, 10'd163, 10'd122, 10'd46};
    tbl[4] = '{12'd625, 9'd104, 10'd130, 10'd97,  10'd58};
    tbl[5] = '{12'd781, 9'd83,  10'd103, 10'd77,  10'd73};

    runs[0] = '{1'b0, 10'd320,  10'd240,  10'd24,  12'd320, -1, 6,  0, 20};
    runs[1] = '{1'b0, 10'd320,  10'd240,  10'd24,  12'd320,  2, 6,  0, 20};
    runs[2] = '{1'b1, 10'd1023, 10'd1023, 10'd4,   12'd64,  -1, 16, 1, 1};
    runs[3] = '{1'b1, 10'd320,  10'd240,  10'd24,  12'd0,   -1, 1,  0, 1};
    runs[4] = '{1'b0, 10'd320,  10'd240,  10'd400, 12'd320, -1, 0,  0, 20};
    runs[5] = '{1'b0, 10'd1023, 10'd1023, 10'd1,   12'd512, -1, 4,  2, 1};

    reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
    img_w = '0; img_h = '0; base_win = '0; step = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {busy, out_valid, done}, 0);
    chk("reset_record", {out_idx, out_scale, out_inv, out_w, out_h, out_win}, 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) do_run(runs[i]);

    // Reset in the middle of record 3's division.
    @(negedge clk);
    mode = 1'b0; img_w = 10'd320; img_h = 10'd240; base_win = 10'd24; step = 12'd320;
    start = 1'b1; out_ready = 1'b1;
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 500) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (out_valid) hs++;
    end
    chk("pre_reset_records", hs, 3);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("busy_before_reset", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrun_reset_flags", {busy, out_valid, done}, 0);
    chk("midrun_reset_record", {out_idx, out_scale, out_inv, out_w, out_h, out_win}, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || out_valid || busy) done_seen++;
    end
    chk("quiet_after_reset", done_seen, 0);
    do_run(runs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
